// File: rtl/dram_tile_loader.sv
// dram_tile_loader: fetches one feature-map tile from DRAM as narrow beats,
// packs BPW beats (first beat in the LSBs) into one WORD_W word and presents
// it to the SRAM top with a valid/ready handshake. Pulses start to launch
// the SRAM controller at tile begin and tile_done after the last word.
//
// Optional feature macro: LOADER_PARITY_EN enables even-parity checking of
// each accepted beat with a sticky par_err flag. When it is undefined,
// dram_par is ignored and par_err is tied low.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   tile_go                  request one tile load (honoured only in IDLE)
//   dram_valid/dram_ready    beat handshake, dram_data payload, dram_par parity
//   word_valid/word_ready    word handshake, word_data packed payload
//   start                    one-cycle pulse at tile begin
//   busy                     high in every state except IDLE
//   tile_done                one-cycle pulse after the last word is accepted
//   par_err                  sticky parity error flag
//
// Assumes WORD_W is an integer multiple of BEAT_W with BPW >= 2.
module dram_tile_loader #(
  parameter int unsigned CH_OUT         = 32,
  parameter int unsigned BEAT_W         = 64,
  parameter int unsigned WORDS_PER_TILE = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tile_go,
  input  logic                   dram_valid,
  input  logic [BEAT_W-1:0]      dram_data,
  input  logic                   dram_par,
  output logic                   dram_ready,
  output logic                   word_valid,
  output logic [CH_OUT*8-1:0]    word_data,
  input  logic                   word_ready,
  output logic                   start,
  output logic                   busy,
  output logic                   tile_done,
  output logic                   par_err
);

  localparam int unsigned WORD_W = CH_OUT * 8;
  localparam int unsigned BPW    = WORD_W / BEAT_W;
  localparam int unsigned BC_W   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WC_W   = $clog2(WORDS_PER_TILE + 1);
  localparam int unsigned PBUF_W = (BPW - 1) * BEAT_W;

  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BPW - 1);
  localparam logic [WC_W-1:0] WORDS_MAX = WC_W'(WORDS_PER_TILE);

  typedef enum logic [1:0] {IDLE, START, FILL, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [BC_W-1:0]     beat_cnt;
  logic [WC_W-1:0]     word_cnt;
  logic [WC_W-1:0]     words_issued;
  logic [PBUF_W-1:0]   pack_buf;
  logic [WORD_W-1:0]   word_next;
  logic                beat_xfer;
  logic                word_xfer;
  logic                word_complete;

  // The final beat bypasses the buffer and lands directly in the top slot.
  assign word_next     = {dram_data, pack_buf};
  assign beat_xfer     = dram_valid & dram_ready;
  assign word_xfer     = word_valid & word_ready;
  assign word_complete = beat_xfer & (beat_cnt == LAST_BEAT);

  // Refuse the completing beat while a stalled word still occupies the output.
  always_comb begin
    dram_ready = (state == FILL) && (words_issued < WORDS_MAX) &&
                 !((beat_cnt == LAST_BEAT) && word_valid && !word_ready);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tile_go) next_state = START;
      START:   next_state = FILL;
      FILL:    if ((word_cnt == WORDS_MAX) && !word_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start     <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      start     <= (next_state == START);
      busy      <= (next_state != IDLE);
      tile_done <= (next_state == DONE);
    end
  end

  // Beat packing, output word register and tile counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      word_cnt     <= '0;
      words_issued <= '0;
      pack_buf     <= '0;
      word_valid   <= 1'b0;
      word_data    <= '0;
    end else if (state == START) begin
      beat_cnt     <= '0;
      word_cnt     <= '0;
      words_issued <= '0;
      word_valid   <= 1'b0;
    end else begin
      if (beat_xfer) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt     <= '0;
          words_issued <= words_issued + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        for (int unsigned k = 0; k < BPW - 1; k++) begin
          if (beat_cnt == BC_W'(k)) pack_buf[k*BEAT_W +: BEAT_W] <= dram_data;
        end
      end
      // A completing word takes priority so back-to-back words need no bubble.
      if (word_complete) begin
        word_data  <= word_next;
        word_valid <= 1'b1;
      end else if (word_xfer) begin
        word_valid <= 1'b0;
      end
      if (word_xfer) word_cnt <= word_cnt + 1'b1;
    end
  end

`ifdef LOADER_PARITY_EN
  // Sticky even-parity error; cleared when the next tile starts.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   par_err <= 1'b0;
    else if (next_state == START)                 par_err <= 1'b0;
    else if (beat_xfer && ^{dram_data, dram_par}) par_err <= 1'b1;
  end
`else
  logic unused_par;
  assign unused_par = dram_par;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dram_tile_loader.sv
// Directed bench for dram_tile_loader: reset, streaming, backpressure,
// gapped traffic, ignored tile_go and parity handling.
module tb_dram_tile_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tile_go;
  logic         dram_valid;
  logic [63:0]  dram_data;
  logic         dram_par;
  logic         dram_ready;
  logic         word_valid;
  logic [255:0] word_data;
  logic         word_ready;
  logic         start;
  logic         busy;
  logic         tile_done;
  logic         par_err;

  always #5 clk = ~clk;

  dram_tile_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tile_go    (tile_go),
    .dram_valid (dram_valid),
    .dram_data  (dram_data),
    .dram_par   (dram_par),
    .dram_ready (dram_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .start      (start),
    .busy       (busy),
    .tile_done  (tile_done),
    .par_err    (par_err)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int beat_idx, starts, dones, start_cyc, done_cyc, first_word_cyc, last_word_cyc;
  int b57_cyc, perr_first_cyc;
  logic corrupt57 = 1'b0;
  logic [255:0] got[$];

  logic o_dr, o_wv, o_start, o_busy, o_done, o_perr;
  logic [255:0] o_wd;

  function automatic logic [255:0] exp_word(input int n);
    logic [63:0] b0, b1, b2, b3;
    b0 = 64'(4 * n);
    b1 = 64'(4 * n + 1);
    b2 = 64'(4 * n + 2);
    b3 = 64'(4 * n + 3);
    return {b3, b2, b1, b0};
  endfunction

  // One clock: drive inputs at negedge, observe 1 time unit later.
  task automatic step(input logic tg, input logic dv, input logic wr);
    @(negedge clk);
    tile_go    = tg;
    dram_valid = dv;
    dram_data  = 64'(beat_idx);
    dram_par   = (^dram_data) ^ (corrupt57 && (beat_idx == 57));
    word_ready = wr;
    #1;
    o_dr = dram_ready; o_wv = word_valid; o_wd = word_data;
    o_start = start; o_busy = busy; o_done = tile_done; o_perr = par_err;
    if (start) begin starts++; start_cyc = cyc; end
    if (tile_done) begin dones++; done_cyc = cyc; end
    if (par_err && perr_first_cyc < 0) perr_first_cyc = cyc;
    if (dram_valid && dram_ready) begin
      if (beat_idx == 57) b57_cyc = cyc;
      beat_idx++;
    end
    if (word_valid && word_ready) begin
      if (got.size() == 0) first_word_cyc = cyc;
      got.push_back(word_data);
      last_word_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic clear_stats();
    got.delete();
    beat_idx = 0; starts = 0; dones = 0; start_cyc = -1; done_cyc = -1;
    first_word_cyc = -1; last_word_cyc = -1; b57_cyc = -1; perr_first_cyc = -1;
  endtask

  task automatic test_reset();
    clear_stats();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_total++; if (o_dr !== 1'b0)    $display("FAIL rst_dram_ready got=%0h want=0", o_dr);    else n_pass++;
    n_total++; if (o_wv !== 1'b0)    $display("FAIL rst_word_valid got=%0h want=0", o_wv);    else n_pass++;
    n_total++; if (o_start !== 1'b0) $display("FAIL rst_start got=%0h want=0", o_start);      else n_pass++;
    n_total++; if (o_busy !== 1'b0)  $display("FAIL rst_busy got=%0h want=0", o_busy);        else n_pass++;
    n_total++; if (o_done !== 1'b0)  $display("FAIL rst_tile_done got=%0h want=0", o_done);   else n_pass++;
    n_total++; if (o_perr !== 1'b0)  $display("FAIL rst_par_err got=%0h want=0", o_perr);     else n_pass++;
    n_total++; if (o_wd !== 256'd0)  $display("FAIL rst_word_data got=%0h want=0", o_wd);     else n_pass++;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    // Abort a tile mid-FILL.
    step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b1);
    n_total++; if (o_busy !== 1'b1) $display("FAIL midfill_busy got=%0h want=1", o_busy); else n_pass++;
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    n_total++; if (o_dr !== 1'b0)   $display("FAIL midrst_dram_ready got=%0h want=0", o_dr); else n_pass++;
    n_total++; if (o_wv !== 1'b0)   $display("FAIL midrst_word_valid got=%0h want=0", o_wv); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL midrst_busy got=%0h want=0", o_busy);     else n_pass++;
    n_total++; if (o_wd !== 256'd0) $display("FAIL midrst_word_data got=%0h want=0", o_wd);  else n_pass++;
    step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (10) step(1'b0, 1'b1, 1'b1);
    n_total++; if (dones !== 0)     $display("FAIL midrst_no_done got=%0d want=0", dones);   else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL midrst_idle got=%0h want=0", o_busy);     else n_pass++;
  endtask

  task automatic test_streaming();
    int go_cyc, bad;
    logic [255:0] w0;
    clear_stats();
    go_cyc = cyc;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && dones == 0; i++) step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    w0 = (got.size() > 0) ? got[0] : '0;
    n_total++; if (starts !== 1) $display("FAIL stream_start_count got=%0d want=1", starts); else n_pass++;
    n_total++; if (start_cyc !== go_cyc + 1) $display("FAIL stream_start_lat got=%0d want=%0d", start_cyc, go_cyc + 1); else n_pass++;
    n_total++; if (first_word_cyc !== go_cyc + 6) $display("FAIL stream_first_word got=%0d want=%0d", first_word_cyc, go_cyc + 6); else n_pass++;
    n_total++; if (w0 !== exp_word(0)) $display("FAIL stream_word0 got=%0h want=%0h", w0, exp_word(0)); else n_pass++;
    n_total++; if (got.size() !== 36) $display("FAIL stream_word_count got=%0d want=36", got.size()); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL stream_word_data bad=%0d want=0", bad); else n_pass++;
    n_total++; if (beat_idx !== 144) $display("FAIL stream_beats got=%0d want=144", beat_idx); else n_pass++;
    n_total++; if (last_word_cyc - first_word_cyc !== 140) $display("FAIL stream_span got=%0d want=140", last_word_cyc - first_word_cyc); else n_pass++;
    n_total++; if (dones !== 1) $display("FAIL stream_done_count got=%0d want=1", dones); else n_pass++;
    n_total++; if (done_cyc !== last_word_cyc + 2) $display("FAIL stream_done_lat got=%0d want=%0d", done_cyc, last_word_cyc + 2); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL stream_idle got=%0h want=0", o_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    int dr_low, bad_hold, bad;
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 100 && got.size() < 2; i++) step(1'b0, 1'b1, 1'b1);
    // Word 2 appears 3 cycles into the stall and must hold for the rest.
    dr_low = 0; bad_hold = 0;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!o_dr) dr_low++;
      if (j >= 3 && (o_wv !== 1'b1 || o_wd !== exp_word(2))) bad_hold++;
    end
    n_total++; if (bad_hold !== 0) $display("FAIL bp_hold bad=%0d want=0", bad_hold); else n_pass++;
    n_total++; if (dr_low !== 4) $display("FAIL bp_ready_low got=%0d want=4", dr_low); else n_pass++;
    n_total++; if (beat_idx !== 15) $display("FAIL bp_beats_in_stall got=%0d want=15", beat_idx); else n_pass++;
    n_total++; if (got.size() !== 2) $display("FAIL bp_words_in_stall got=%0d want=2", got.size()); else n_pass++;
    for (int i = 0; i < 400 && dones == 0; i++) step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    n_total++; if (got.size() !== 36) $display("FAIL bp_word_count got=%0d want=36", got.size()); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL bp_word_data bad=%0d want=0", bad); else n_pass++;
    n_total++; if (beat_idx !== 144) $display("FAIL bp_beats got=%0d want=144", beat_idx); else n_pass++;
    n_total++; if (dones !== 1) $display("FAIL bp_done_count got=%0d want=1", dones); else n_pass++;
  endtask

  task automatic test_gaps();
    int bad;
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3000 && dones == 0; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (3) step(1'b0, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    n_total++; if (got.size() !== 36) $display("FAIL gaps_word_count got=%0d want=36", got.size()); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL gaps_word_data bad=%0d want=0", bad); else n_pass++;
    n_total++; if (beat_idx !== 144) $display("FAIL gaps_beats got=%0d want=144", beat_idx); else n_pass++;
    n_total++; if (dones !== 1) $display("FAIL gaps_done_count got=%0d want=1", dones); else n_pass++;
    n_total++; if (done_cyc !== last_word_cyc + 2) $display("FAIL gaps_done_lat got=%0d want=%0d", done_cyc, last_word_cyc + 2); else n_pass++;
  endtask

  task automatic test_go_ignored();
    int bad;
    clear_stats();
    repeat (40) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && dones == 0; i++) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    n_total++; if (starts !== 1) $display("FAIL go_ignored_starts got=%0d want=1", starts); else n_pass++;
    n_total++; if (got.size() !== 36 || bad !== 0) $display("FAIL go_ignored_words count=%0d bad=%0d want=36/0", got.size(), bad); else n_pass++;
    // Second tile from IDLE.
    got.delete();
    beat_idx = 0;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && dones < 2; i++) step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    n_total++; if (starts !== 2) $display("FAIL second_tile_starts got=%0d want=2", starts); else n_pass++;
    n_total++; if (got.size() !== 36 || bad !== 0) $display("FAIL second_tile_words count=%0d bad=%0d want=36/0", got.size(), bad); else n_pass++;
    n_total++; if (dones !== 2) $display("FAIL second_tile_dones got=%0d want=2", dones); else n_pass++;
  endtask

  task automatic test_parity();
    int drops, bad;
    logic perr_at_done;
    clear_stats();
    corrupt57 = 1'b1;
    drops = 0;
    perr_at_done = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && dones == 0; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (o_done) perr_at_done = o_perr;
      else if (perr_first_cyc >= 0 && !o_perr) drops++;
    end
    repeat (2) step(1'b0, 1'b1, 1'b1);
    corrupt57 = 1'b0;
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_word(i)) bad++;
    n_total++; if (got.size() !== 36 || bad !== 0) $display("FAIL par_words count=%0d bad=%0d want=36/0", got.size(), bad); else n_pass++;
`ifdef LOADER_PARITY_EN
    n_total++; if (b57_cyc < 0 || perr_first_cyc !== b57_cyc + 1) $display("FAIL par_set_lat got=%0d want=%0d", perr_first_cyc, b57_cyc + 1); else n_pass++;
    n_total++; if (perr_at_done !== 1'b1) $display("FAIL par_held_at_done got=%0h want=1", perr_at_done); else n_pass++;
    n_total++; if (drops !== 0) $display("FAIL par_sticky drops=%0d want=0", drops); else n_pass++;
`else
    n_total++; if (perr_first_cyc !== -1) $display("FAIL par_disabled first=%0d want=-1", perr_first_cyc); else n_pass++;
`endif
    // Next tile clears the flag at START.
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_total++; if (o_perr !== 1'b0) $display("FAIL par_clear_on_start got=%0h want=0", o_perr); else n_pass++;
    for (int i = 0; i < 400 && dones == 0; i++) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; tile_go = 1'b0; dram_valid = 1'b0; dram_data = '0;
    dram_par = 1'b0; word_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_gaps();
    test_go_ignored();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
